alu_issue_stage: RTL and testbench

- ID/EX pipeline stage that drives the ALU interface: it decodes RV32I integer instructions into ALU_operation_t plus A/B operands and registers them for the execute stage.
- It is the producer side of the ALU's operation/A/B inputs. It sits between register-file read and the combinational ALU.
- It uses a valid/ready handshake on both sides, with stall and flush.

---
 rtl/alu_issue_stage_pkg.sv | 65 ++++++
 rtl/alu_issue_stage_decoder.sv | 88 ++++++++
 rtl/alu_issue_stage.sv | 86 ++++++++
 tb/tb_alu_issue_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_stage_pkg.sv
// Shared types and constants for the ALU issue stage: ALU operation encoding,
// RV32I opcode/funct7 constants and the decoder result bundle.
package alu_issue_stage_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned REG_W   = 5;

  typedef enum logic [3:0] {
    addALU  = 4'd0,
    subALU  = 4'd1,
    sllALU  = 4'd2,
    sltALU  = 4'd3,
    sltuALU = 4'd4,
    xorALU  = 4'd5,
    srlALU  = 4'd6,
    sraALU  = 4'd7,
    orALU   = 4'd8,
    andALU  = 4'd9
  } ALU_operation_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    ASEL_ZERO = 2'd0,
    ASEL_RS1  = 2'd1,
    ASEL_PC   = 2'd2
  } a_sel_t;

  typedef enum logic [1:0] {
    BSEL_ZERO = 2'd0,
    BSEL_RS2  = 2'd1,
    BSEL_IMM  = 2'd2
  } b_sel_t;

  typedef struct packed {
    ALU_operation_t     op;
    a_sel_t             a_sel;
    b_sel_t             b_sel;
    logic [INSTR_W-1:0] imm;
    logic [REG_W-1:0]   rd;
    logic               reg_write;
    logic               illegal;
  } dec_t;

  // funct3 to operation for the funct7=0000000 encodings shared by OP and OP-IMM
  function automatic ALU_operation_t base_op(input logic [2:0] funct3);
    case (funct3)
      3'b000:  base_op = addALU;
      3'b001:  base_op = sllALU;
      3'b010:  base_op = sltALU;
      3'b011:  base_op = sltuALU;
      3'b100:  base_op = xorALU;
      3'b101:  base_op = srlALU;
      3'b110:  base_op = orALU;
      default: base_op = andALU;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_stage_decoder.sv
// Combinational RV32I integer decoder: instruction word to ALU operation,
// operand selects, immediate, destination and legality.
module alu_op_decoder
  import alu_issue_stage_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output dec_t               dec_c
);

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic [INSTR_W-1:0] imm_i;
  logic [INSTR_W-1:0] imm_u;
  logic [INSTR_W-1:0] imm_sh;
  logic               bad;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_sh = {27'b0, instr[24:20]};

  always_comb begin
    dec_c    = '0;
    dec_c.op = addALU;
    bad      = 1'b0;

    case (opcode)
      OPC_OP: begin
        dec_c.a_sel = ASEL_RS1;
        dec_c.b_sel = BSEL_RS2;
        if (funct7 == F7_BASE) begin
          dec_c.op = base_op(funct3);
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          dec_c.op = subALU;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          dec_c.op = sraALU;
        end else begin
          bad = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec_c.a_sel = ASEL_RS1;
        dec_c.b_sel = BSEL_IMM;
        dec_c.op    = base_op(funct3);
        dec_c.imm   = imm_i;
        // shift-immediates carry shamt in [24:20] and a funct7 qualifier above it
        if (funct3 == 3'b001) begin
          dec_c.imm = imm_sh;
          bad       = (funct7 != F7_BASE);
        end else if (funct3 == 3'b101) begin
          dec_c.imm = imm_sh;
          if (funct7 == F7_ALT) begin
            dec_c.op = sraALU;
          end else begin
            bad = (funct7 != F7_BASE);
          end
        end
      end
      OPC_LUI: begin
        dec_c.a_sel = ASEL_ZERO;
        dec_c.b_sel = BSEL_IMM;
        dec_c.imm   = imm_u;
      end
      OPC_AUIPC: begin
        dec_c.a_sel = ASEL_PC;
        dec_c.b_sel = BSEL_IMM;
        dec_c.imm   = imm_u;
      end
      default: bad = 1'b1;
    endcase

    // illegal instructions still issue, but as a harmless 0+0 with no write-back
    if (bad) begin
      dec_c.op    = addALU;
      dec_c.a_sel = ASEL_ZERO;
      dec_c.b_sel = BSEL_ZERO;
      dec_c.imm   = '0;
    end

    dec_c.rd        = instr[11:7];
    dec_c.illegal   = bad;
    dec_c.reg_write = !bad && (instr[11:7] != 5'd0);
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes RV32I integer instructions and registers the
// ALU request behind a valid/ready handshake with stall and flush.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  output logic                 id_ready,
  input  logic [INSTR_W-1:0]   instr,
  input  logic [XLEN-1:0]      pc,
  input  logic [XLEN-1:0]      rs1_data,
  input  logic [XLEN-1:0]      rs2_data,
  input  logic                 flush,
  output logic                 ex_valid,
  input  logic                 ex_ready,
  output ALU_operation_t       alu_op,
  output logic [XLEN-1:0]      alu_a,
  output logic [XLEN-1:0]      alu_b,
  output logic [REG_W-1:0]     rd,
  output logic                 reg_write,
  output logic                 illegal,
  output logic [CNT_W-1:0]     issued_count
);

  dec_t            dec_c;
  logic [XLEN-1:0] op_a_c;
  logic [XLEN-1:0] op_b_c;
  logic            accept_c;

  alu_op_decoder u_dec (
    .instr (instr),
    .dec_c (dec_c)
  );

  // the slot is free when empty or being drained this cycle
  assign id_ready = !ex_valid || ex_ready;
  assign accept_c = id_valid && id_ready && !flush;

  // operand muxes
  always_comb begin
    op_a_c = '0;
    op_b_c = '0;
    case (dec_c.a_sel)
      ASEL_RS1: op_a_c = rs1_data;
      ASEL_PC:  op_a_c = pc;
      default:  op_a_c = '0;
    endcase
    case (dec_c.b_sel)
      BSEL_RS2: op_b_c = rs2_data;
      BSEL_IMM: op_b_c = XLEN'(dec_c.imm);
      default:  op_b_c = '0;
    endcase
  end

  // pipeline register and issue counter; flush wins over accept and stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      alu_op       <= addALU;
      alu_a        <= '0;
      alu_b        <= '0;
      rd           <= '0;
      reg_write    <= 1'b0;
      illegal      <= 1'b0;
      issued_count <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (accept_c) begin
      ex_valid     <= 1'b1;
      alu_op       <= dec_c.op;
      alu_a        <= op_a_c;
      alu_b        <= op_b_c;
      rd           <= dec_c.rd;
      reg_write    <= dec_c.reg_write;
      illegal      <= dec_c.illegal;
      issued_count <= issued_count + CNT_W'(1);
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode, handshake, stall, flush,
// illegal encodings, reset mid-stall and counter wrap.
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned OBS_W = 76 + CNT_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              id_valid = 1'b0;
  logic              id_ready;
  logic [31:0]       instr = '0;
  logic [31:0]       pc = '0;
  logic [31:0]       rs1_data = '0;
  logic [31:0]       rs2_data = '0;
  logic              flush = 1'b0;
  logic              ex_valid;
  logic              ex_ready = 1'b0;
  ALU_operation_t    alu_op;
  logic [31:0]       alu_a;
  logic [31:0]       alu_b;
  logic [4:0]        rd;
  logic              reg_write;
  logic              illegal;
  logic [CNT_W-1:0]  issued_count;

  logic [OBS_W-1:0]  obs;
  logic [OBS_W-1:0]  want;
  int                vecs = 0;
  int                errs = 0;

  alu_issue_stage #(.XLEN(32), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .instr        (instr),
    .pc           (pc),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .flush        (flush),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .alu_op       (alu_op),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .rd           (rd),
    .reg_write    (reg_write),
    .illegal      (illegal),
    .issued_count (issued_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] a,
                       input logic [31:0] b, input logic rdy);
    id_valid = v;
    instr    = i;
    rs1_data = a;
    rs2_data = b;
    ex_ready = rdy;
  endtask

  task automatic sample();
    obs = {ex_valid, alu_op, alu_a, alu_b, rd, reg_write, illegal, issued_count};
  endtask

  task automatic test_reset();
    sample();
    want = {1'b0, addALU, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 4'd0};
    vecs++; if (obs !== want) begin errs++; $display("FAIL reset_state: got %h want %h", obs, want); end
    vecs++; if (id_ready !== 1'b1) begin errs++; $display("FAIL reset_id_ready: got %b want 1", id_ready); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_add();
    drive(1'b1, 32'h002081B3, 32'd15, 32'd20, 1'b1);
    step();
    drive(1'b0, 32'h0, 32'd0, 32'd0, 1'b1);
    sample();
    want = {1'b1, addALU, 32'd15, 32'd20, 5'd3, 1'b1, 1'b0, 4'd1};
    vecs++; if (obs !== want) begin errs++; $display("FAIL add: got %h want %h", obs, want); end
    step();
    vecs++; if (ex_valid !== 1'b0) begin errs++; $display("FAIL add_drain: ex_valid got %b want 0", ex_valid); end
  endtask

  task automatic test_stall_back_to_back();
    drive(1'b1, 32'h402081B3, 32'd15, 32'd20, 1'b0);
    step();
    want = {1'b1, subALU, 32'd15, 32'd20, 5'd3, 1'b1, 1'b0, 4'd2};
    // upstream keeps presenting with different operand data while stalled
    rs1_data = 32'd99;
    for (int c = 0; c < 3; c++) begin
      sample();
      vecs++; if (obs !== want) begin errs++; $display("FAIL sub_stall%0d: got %h want %h", c, obs, want); end
      vecs++; if (id_ready !== 1'b0) begin errs++; $display("FAIL stall_id_ready%0d: got %b want 0", c, id_ready); end
      step();
    end
    drive(1'b1, 32'h002081B3, 32'd1, 32'd2, 1'b1);
    #1;
    vecs++; if (id_ready !== 1'b1) begin errs++; $display("FAIL drain_id_ready: got %b want 1", id_ready); end
    step();
    drive(1'b0, 32'h0, 32'd0, 32'd0, 1'b1);
    sample();
    want = {1'b1, addALU, 32'd1, 32'd2, 5'd3, 1'b1, 1'b0, 4'd3};
    vecs++; if (obs !== want) begin errs++; $display("FAIL back_to_back: got %h want %h", obs, want); end
    step();
    vecs++; if (ex_valid !== 1'b0) begin errs++; $display("FAIL b2b_drain: ex_valid got %b want 0", ex_valid); end
  endtask

  task automatic test_imm_forms();
    drive(1'b1, 32'h4020D293, 32'h8000_0000, 32'h5555_5555, 1'b1);
    step();
    sample();
    want = {1'b1, sraALU, 32'h8000_0000, 32'd2, 5'd5, 1'b1, 1'b0, 4'd4};
    vecs++; if (obs !== want) begin errs++; $display("FAIL srai: got %h want %h", obs, want); end
    pc = 32'h0000_1000;
    drive(1'b1, 32'h123450B7, 32'h0000_DEAD, 32'h0000_BEEF, 1'b1);
    step();
    sample();
    want = {1'b1, addALU, 32'd0, 32'h1234_5000, 5'd1, 1'b1, 1'b0, 4'd5};
    vecs++; if (obs !== want) begin errs++; $display("FAIL lui: got %h want %h", obs, want); end
    drive(1'b1, 32'hFFF08093, 32'd5, 32'd7, 1'b1);
    step();
    sample();
    want = {1'b1, addALU, 32'd5, 32'hFFFF_FFFF, 5'd1, 1'b1, 1'b0, 4'd6};
    vecs++; if (obs !== want) begin errs++; $display("FAIL addi: got %h want %h", obs, want); end
    pc = 32'h0000_0400;
    drive(1'b1, 32'h00001117, 32'd5, 32'd7, 1'b1);
    step();
    drive(1'b0, 32'h0, 32'd0, 32'd0, 1'b1);
    sample();
    want = {1'b1, addALU, 32'h0000_0400, 32'h0000_1000, 5'd2, 1'b1, 1'b0, 4'd7};
    vecs++; if (obs !== want) begin errs++; $display("FAIL auipc: got %h want %h", obs, want); end
    step();
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h002081B3, 32'd1, 32'd2, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    vecs++; if (ex_valid !== 1'b0) begin errs++; $display("FAIL flush_in_valid: got %b want 0", ex_valid); end
    vecs++; if (issued_count !== 4'd7) begin errs++; $display("FAIL flush_in_count: got %0d want 7", issued_count); end
    drive(1'b1, 32'h002081B3, 32'd1, 32'd2, 1'b0);
    step();
    vecs++; if (issued_count !== 4'd8) begin errs++; $display("FAIL pre_flush_count: got %0d want 8", issued_count); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'd0, 32'd0, 1'b0);
    vecs++; if (ex_valid !== 1'b0) begin errs++; $display("FAIL flush_stall_valid: got %b want 0", ex_valid); end
    vecs++; if (issued_count !== 4'd8) begin errs++; $display("FAIL flush_stall_count: got %0d want 8", issued_count); end
    step();
  endtask

  task automatic test_illegal();
    drive(1'b1, 32'h0000007F, 32'd7, 32'd9, 1'b1);
    step();
    sample();
    want = {1'b1, addALU, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 4'd9};
    vecs++; if (obs !== want) begin errs++; $display("FAIL illegal_opcode: got %h want %h", obs, want); end
    drive(1'b1, 32'h202081B3, 32'd7, 32'd9, 1'b1);
    step();
    sample();
    want = {1'b1, addALU, 32'd0, 32'd0, 5'd3, 1'b0, 1'b1, 4'd10};
    vecs++; if (obs !== want) begin errs++; $display("FAIL illegal_funct7: got %h want %h", obs, want); end
    drive(1'b1, 32'h00208033, 32'd1, 32'd2, 1'b1);
    step();
    drive(1'b0, 32'h0, 32'd0, 32'd0, 1'b1);
    sample();
    want = {1'b1, addALU, 32'd1, 32'd2, 5'd0, 1'b0, 1'b0, 4'd11};
    vecs++; if (obs !== want) begin errs++; $display("FAIL add_x0: got %h want %h", obs, want); end
    step();
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 32'h4020D293, 32'h8000_0000, 32'd0, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'd0, 32'd0, 1'b0);
    step();
    vecs++; if (ex_valid !== 1'b1) begin errs++; $display("FAIL pre_reset_valid: got %b want 1", ex_valid); end
    rst = 1'b1;
    #1;
    sample();
    want = {1'b0, addALU, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 4'd0};
    vecs++; if (obs !== want) begin errs++; $display("FAIL reset_mid_stall: got %h want %h", obs, want); end
    vecs++; if (id_ready !== 1'b1) begin errs++; $display("FAIL reset_mid_id_ready: got %b want 1", id_ready); end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_count_wrap();
    drive(1'b1, 32'h002081B3, 32'd1, 32'd2, 1'b1);
    for (int k = 0; k < 15; k++) step();
    vecs++; if (issued_count !== 4'hF) begin errs++; $display("FAIL count_full: got %0d want 15", issued_count); end
    step();
    drive(1'b0, 32'h0, 32'd0, 32'd0, 1'b1);
    vecs++; if (issued_count !== 4'h0) begin errs++; $display("FAIL count_wrap: got %0d want 0", issued_count); end
    vecs++; if (ex_valid !== 1'b1) begin errs++; $display("FAIL wrap_valid: got %b want 1", ex_valid); end
    step();
  endtask

  initial begin
    step();
    step();
    test_reset();
    test_add();
    test_stall_back_to_back();
    test_imm_forms();
    test_flush();
    test_illegal();
    test_reset_mid_stall();
    test_count_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
